// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
package clk_div_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int MIN_DIV   = 2;

  // Channel-select width; a single channel still needs a one-bit select port.
  function automatic int cw_of(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: period counter, shadow/active divisor registers and
// registered divided-clock / tick outputs.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int DEF_DIV = 4
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_we,
  input  logic [WIDTH-1:0] cfg_div,
  input  logic [WIDTH-1:0] cfg_high,
  output logic             clk_div,
  output logic             tick,
  output logic             cfg_pend
);

  localparam logic [WIDTH-1:0] RST_DIV  = WIDTH'(DEF_DIV);
  localparam logic [WIDTH-1:0] RST_HIGH = WIDTH'(DEF_DIV / 2);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  function automatic logic [WIDTH-1:0] eff_period(input logic [WIDTH-1:0] div);
    return (div < WIDTH'(MIN_DIV)) ? WIDTH'(MIN_DIV) : div;
  endfunction

  logic [WIDTH-1:0] cnt_p0, cnt_nxt;
  logic [WIDTH-1:0] div_a, high_a, div_s, high_s;
  logic [WIDTH-1:0] div_a_nxt, high_a_nxt, div_s_nxt, high_s_nxt;
  logic             run_p0;
  logic             pend, pend_nxt;
  logic             live, last, reload;
  logic             clk_div_p1, tick_p1;

  always_comb begin
    live       = run_p0 && en;
    last       = (cnt_p0 >= eff_period(div_a) - ONE);
    // Idle or just-enabled channels start a fresh period, so they may load at once.
    reload     = !live || last;
    cnt_nxt    = (live && !last) ? cnt_p0 + ONE : '0;
    div_s_nxt  = div_s;
    high_s_nxt = high_s;
    div_a_nxt  = div_a;
    high_a_nxt = high_a;
    pend_nxt   = pend;
    if (cfg_we) begin
      div_s_nxt  = cfg_div;
      high_s_nxt = cfg_high;
      if (reload) begin
        div_a_nxt  = cfg_div;
        high_a_nxt = cfg_high;
        pend_nxt   = 1'b0;
      end else begin
        pend_nxt   = 1'b1;
      end
    end else if (reload) begin
      div_a_nxt  = div_s;
      high_a_nxt = high_s;
      pend_nxt   = 1'b0;
    end
  end

  // Stage p0: counter and configuration state
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      cnt_p0 <= '0;
      run_p0 <= 1'b0;
      div_a  <= RST_DIV;
      high_a <= RST_HIGH;
      div_s  <= RST_DIV;
      high_s <= RST_HIGH;
      pend   <= 1'b0;
    end else begin
      cnt_p0 <= cnt_nxt;
      run_p0 <= en;
      div_a  <= div_a_nxt;
      high_a <= high_a_nxt;
      div_s  <= div_s_nxt;
      high_s <= high_s_nxt;
      pend   <= pend_nxt;
    end
  end

  // Stage p1: outputs registered from the next-state values so they align with cnt_p0
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      clk_div_p1 <= 1'b0;
      tick_p1    <= 1'b0;
    end else begin
      clk_div_p1 <= en && (cnt_nxt < high_a_nxt);
      tick_p1    <= en && (cnt_nxt == '0);
    end
  end

  assign clk_div  = clk_div_p1;
  assign tick     = tick_p1;
  assign cfg_pend = pend;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable divided-clock / tick generator: decodes the
// configuration port and replicates one divider channel per output.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int DEF_DIV = 4,
  localparam int CW     = cw_of(NUM_CH)
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
  input  logic              cfg_we,
  input  logic [CW-1:0]     cfg_sel,
  input  logic [WIDTH-1:0]  cfg_div,
  input  logic [WIDTH-1:0]  cfg_high,
  output logic [NUM_CH-1:0] clk_div,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] cfg_pend
);

  logic [NUM_CH-1:0] we_ch;

  // Only in-range indices are decoded, so a select at or beyond NUM_CH hits nothing.
  always_comb begin
    we_ch = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_we && (cfg_sel == CW'(i))) begin
        we_ch[i] = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    clk_div_chan #(
      .WIDTH   (WIDTH),
      .DEF_DIV (DEF_DIV)
    ) u_chan (
      .clk_in   (clk_in),
      .rst      (rst),
      .en       (en[g]),
      .cfg_we   (we_ch[g]),
      .cfg_div  (cfg_div),
      .cfg_high (cfg_high),
      .clk_div  (clk_div[g]),
      .tick     (tick[g]),
      .cfg_pend (cfg_pend[g])
    );
  end

endmodule
